// File: rtl/dsp_i2s_pkg.sv
// Constants and helpers shared by the I2S/TDM transmit and receive datapaths.
package dsp_i2s_pkg;

  localparam int I2S_MODE_LJ  = 0;
  localparam int I2S_MODE_I2S = 1;

  // Width of a frame position counter that covers exactly one frame.
  function automatic int posn_width(input int frame_bits);
    return $clog2(frame_bits);
  endfunction

endpackage

// File: rtl/i2s_tx_tdm_if.sv
// Frame-wide valid/ready bus carrying CHANNELS samples of WIDTH bits each.
interface i2s_tx_tdm_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
);

  logic [WIDTH*CHANNELS-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/i2s_frame_hold.sv
// One-frame valid/ready holding register, emptied by a pop strobe at frame start.
module i2s_frame_hold #(
  parameter int DW = 32
) (
  input  logic          ck,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          pop,
  output logic [DW-1:0] hold_data,
  output logic          full
);

  logic [DW-1:0] hold_q, hold_d;
  logic          full_q, full_d;
  logic          accept;

  // A pop frees the slot in the same cycle, so a refill can land alongside it.
  always_comb begin
    in_ready = !full_q || pop;
    accept   = in_valid && in_ready;
    hold_d   = hold_q;
    full_d   = full_q;
    if (accept) begin
      hold_d = in_data;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign hold_data = hold_q;
  assign full      = full_q;

endmodule

// File: rtl/i2s_tx_tdm.sv
// I2S / left-justified TDM transmitter: buffers one frame ahead and shifts
// samples MSB-first into fixed-width slots, paced by the shared frame counter.
module i2s_tx_tdm
  import dsp_i2s_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int SLOT_BITS = 32,
  parameter int POSN_W    = 6,
  parameter int I2S_DELAY = I2S_MODE_I2S
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              en,
  input  logic [POSN_W-1:0] frame_posn,
  i2s_tx_tdm_if.slave       in_if,
  output logic              sd,
  output logic              underrun
);

  localparam int FW   = WIDTH * CHANNELS;
  localparam int SB_W = $clog2(SLOT_BITS);
  localparam int KW   = POSN_W - SB_W;

  if (WIDTH > SLOT_BITS || CHANNELS < 2 ||
      POSN_W != posn_width(CHANNELS * SLOT_BITS) ||
      (1 << POSN_W) != CHANNELS * SLOT_BITS) begin : g_bad_cfg
    $error("i2s_tx_tdm: inconsistent WIDTH/CHANNELS/SLOT_BITS/POSN_W");
  end

  logic                 start;
  logic                 full;
  logic [FW-1:0]        hold_data;
  logic [FW-1:0]        load_frame;
  logic [FW-1:0]        src_frame;
  logic [FW-1:0]        cur_q, cur_d;
  logic [KW-1:0]        slot_idx;
  logic [WIDTH-1:0]     samp;
  logic [SLOT_BITS-1:0] slot_word;
  logic [SLOT_BITS-1:0] shreg_q, shreg_d;
  logic                 dly_q, dly_d;
  logic                 sd_q, sd_d;
  logic                 bit_now;

  assign start = en && (frame_posn == '0);

  i2s_frame_hold #(.DW(FW)) u_hold (
    .ck        (ck),
    .rst       (rst),
    .in_data   (in_if.in_data),
    .in_valid  (in_if.in_valid),
    .in_ready  (in_if.in_ready),
    .pop       (start),
    .hold_data (hold_data),
    .full      (full)
  );

  // At p=0 the frame being loaded is used directly so slot 0 needs no extra cycle.
  assign load_frame = full ? hold_data : '0;
  assign src_frame  = start ? load_frame : cur_q;
  assign slot_idx   = frame_posn[POSN_W-1:SB_W];

  always_comb begin
    samp = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (slot_idx == KW'(k)) samp = src_frame[k*WIDTH +: WIDTH];
    end
    slot_word = SLOT_BITS'(samp) << (SLOT_BITS - WIDTH);
  end

  always_comb begin
    cur_d   = start ? load_frame : cur_q;
    shreg_d = shreg_q;
    dly_d   = dly_q;
    sd_d    = sd_q;
    bit_now = 1'b0;
    if (en) begin
      if (frame_posn[SB_W-1:0] == '0) begin
        bit_now = slot_word[SLOT_BITS-1];
        shreg_d = slot_word << 1;
      end else begin
        bit_now = shreg_q[SLOT_BITS-1];
        shreg_d = shreg_q << 1;
      end
      if (I2S_DELAY == I2S_MODE_I2S) begin
        sd_d  = dly_q;
        dly_d = bit_now;
      end else begin
        sd_d = bit_now;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      cur_q   <= '0;
      shreg_q <= '0;
      dly_q   <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      shreg_q <= shreg_d;
      dly_q   <= dly_d;
      sd_q    <= sd_d;
    end
  end

  assign sd       = sd_q;
  assign underrun = start && !full && !rst;

endmodule

// File: tb/tb_i2s_tx_tdm.sv
// Drives I2S, left-justified and 4-slot TDM instances in lockstep and checks
// them against a frame-level model of the serial bit definition.
module tb_i2s_tx_tdm;
  import dsp_i2s_pkg::*;

  localparam int NI = 3;
  localparam int CFG_W    [NI] = '{16, 16, 24};
  localparam int CFG_SLOT [NI] = '{32, 32, 32};
  localparam int CFG_DLY  [NI] = '{1, 0, 1};
  localparam int CFG_LEN  [NI] = '{64, 64, 128};

  logic          ck  = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [5:0]    fp_a = '0;
  logic [6:0]    fp_b = '0;
  logic [NI-1:0] sd_o, und_o, rdy_o;

  always #5 ck = ~ck;

  i2s_tx_tdm_if #(.WIDTH(16), .CHANNELS(2)) bus0 ();
  i2s_tx_tdm_if #(.WIDTH(16), .CHANNELS(2)) bus1 ();
  i2s_tx_tdm_if #(.WIDTH(24), .CHANNELS(4)) bus2 ();

  assign rdy_o = {bus2.in_ready, bus1.in_ready, bus0.in_ready};

  i2s_tx_tdm #(.WIDTH(16), .CHANNELS(2), .SLOT_BITS(32), .POSN_W(6),
               .I2S_DELAY(I2S_MODE_I2S)) dut_i2s (
    .ck(ck), .rst(rst), .en(en), .frame_posn(fp_a), .in_if(bus0.slave),
    .sd(sd_o[0]), .underrun(und_o[0]));

  i2s_tx_tdm #(.WIDTH(16), .CHANNELS(2), .SLOT_BITS(32), .POSN_W(6),
               .I2S_DELAY(I2S_MODE_LJ)) dut_lj (
    .ck(ck), .rst(rst), .en(en), .frame_posn(fp_a), .in_if(bus1.slave),
    .sd(sd_o[1]), .underrun(und_o[1]));

  i2s_tx_tdm #(.WIDTH(24), .CHANNELS(4), .SLOT_BITS(32), .POSN_W(7),
               .I2S_DELAY(I2S_MODE_I2S)) dut_tdm (
    .ck(ck), .rst(rst), .en(en), .frame_posn(fp_b), .in_if(bus2.slave),
    .sd(sd_o[2]), .underrun(und_o[2]));

  int          posn [NI];
  bit          vin  [NI];
  logic [23:0] din  [NI][4];

  bit          m_full [NI];
  logic [23:0] m_hold [NI][4];
  logic [23:0] m_cur  [NI][4];
  bit          m_prev [NI];
  bit          exp_sd [NI];

  logic [63:0]  cap_i2s, cap_lj;
  logic [127:0] cap_tdm;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Bit at frame position p: MSB-first sample in the slot head, zeros in the tail.
  function automatic bit frame_bit(input int i, input int p, input bit from_load);
    int k;
    int b;
    logic [23:0] s;
    k = p / CFG_SLOT[i];
    b = p % CFG_SLOT[i];
    if (b >= CFG_W[i]) return 1'b0;
    if (from_load) s = m_full[i] ? m_hold[i][k] : 24'h0;
    else           s = m_cur[i][k];
    return s[CFG_W[i]-1-b];
  endfunction

  task automatic cycle(input bit r, input bit e);
    bit start, ready, bitv;
    rst  = r;
    en   = e;
    fp_a = 6'(posn[0]);
    fp_b = 7'(posn[2]);
    bus0.in_valid = vin[0];
    bus0.in_data  = {din[0][1][15:0], din[0][0][15:0]};
    bus1.in_valid = vin[1];
    bus1.in_data  = {din[1][1][15:0], din[1][0][15:0]};
    bus2.in_valid = vin[2];
    bus2.in_data  = {din[2][3], din[2][2], din[2][1], din[2][0]};
    #1;
    for (int i = 0; i < NI; i++) begin
      start = e && (posn[i] == 0);
      ready = !m_full[i] || start;
      if (!r) begin
        chk($sformatf("in_ready%0d", i), 32'(rdy_o[i]), 32'(ready));
        chk($sformatf("underrun%0d", i), 32'(und_o[i]), 32'(start && !m_full[i]));
      end
      if (r) begin
        m_full[i] = 1'b0;
        m_prev[i] = 1'b0;
        exp_sd[i] = 1'b0;
        for (int k = 0; k < 4; k++) m_cur[i][k] = '0;
      end else begin
        if (e) begin
          bitv = frame_bit(i, posn[i], start);
          if (CFG_DLY[i] == 1) begin
            exp_sd[i] = m_prev[i];
            m_prev[i] = bitv;
          end else begin
            exp_sd[i] = bitv;
          end
        end
        if (start)
          for (int k = 0; k < 4; k++) m_cur[i][k] = m_full[i] ? m_hold[i][k] : 24'h0;
        if (vin[i] && ready) begin
          for (int k = 0; k < 4; k++) m_hold[i][k] = din[i][k];
          m_full[i] = 1'b1;
        end else if (start) begin
          m_full[i] = 1'b0;
        end
      end
    end
    @(posedge ck);
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("sd%0d", i), 32'(sd_o[i]), 32'(exp_sd[i]));
    if (e) begin
      cap_i2s = {cap_i2s[62:0], sd_o[0]};
      cap_lj  = {cap_lj[62:0], sd_o[1]};
      cap_tdm = {cap_tdm[126:0], sd_o[2]};
      for (int i = 0; i < NI; i++) posn[i] = (posn[i] + 1) % CFG_LEN[i];
    end
    @(negedge ck);
  endtask

  task automatic rand_inputs(input int div);
    for (int i = 0; i < NI; i++) begin
      vin[i] = ($urandom % div) == 0;
      for (int k = 0; k < 4; k++)
        din[i][k] = (i < 2) ? 24'($urandom & 32'hFFFF) : 24'($urandom);
    end
  endtask

  initial begin
    logic [63:0]  gold_lj, gold_i2s;
    logic [127:0] gold_tdm;
    int guard;

    posn = '{60, 60, 124};
    for (int i = 0; i < NI; i++) begin
      vin[i] = 1'b0;
      for (int k = 0; k < 4; k++) din[i][k] = '0;
    end
    @(negedge ck);
    repeat (3) cycle(1'b1, 1'b0);

    // Known frames loaded a few bits ahead of frame start.
    for (int i = 0; i < 2; i++) begin
      vin[i] = 1'b1;
      din[i][0] = 24'h008001;
      din[i][1] = 24'h007FFE;
    end
    vin[2] = 1'b1;
    din[2][0] = 24'hA5A5A5;
    din[2][1] = 24'h000001;
    din[2][2] = 24'hFFFFFF;
    din[2][3] = 24'h123456;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < NI; i++) vin[i] = 1'b0;

    repeat (67) cycle(1'b0, 1'b1);
    gold_lj  = {16'h8001, 16'h0000, 16'h7FFE, 16'h0000};
    gold_i2s = gold_lj >> 1;
    chk("frame_lj_hi",  cap_lj[63:32],  gold_lj[63:32]);
    chk("frame_lj_lo",  cap_lj[31:0],   gold_lj[31:0]);
    chk("frame_i2s_hi", cap_i2s[63:32], gold_i2s[63:32]);
    chk("frame_i2s_lo", cap_i2s[31:0],  gold_i2s[31:0]);
    repeat (64) cycle(1'b0, 1'b1);
    gold_tdm = {24'hA5A5A5, 8'h0, 24'h000001, 8'h0, 24'hFFFFFF, 8'h0, 24'h123456, 8'h0};
    gold_tdm = gold_tdm >> 1;
    for (int w = 0; w < 4; w++)
      chk($sformatf("frame_tdm_w%0d", w), cap_tdm[w*32 +: 32], gold_tdm[w*32 +: 32]);

    // Every instance now starts empty; refill mid-frame for the following one.
    repeat (10) cycle(1'b0, 1'b1);
    rand_inputs(1);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < NI; i++) vin[i] = 1'b0;
    repeat (150) cycle(1'b0, 1'b1);

    // Valid held high: refills coincide with frame start while full.
    repeat (300) begin
      rand_inputs(1);
      cycle(1'b0, 1'b1);
    end

    for (int seg = 0; seg < 3; seg++) begin
      repeat (600) begin
        rand_inputs(seg == 0 ? 90 : (seg == 1 ? 10 : 2));
        cycle(1'b0, ($urandom % 4) != 0);
      end
    end

    // Reset mid-frame at p=40 of the two-slot frame.
    guard = 0;
    while (posn[0] != 40 && guard < 200) begin
      rand_inputs(4);
      cycle(1'b0, 1'b1);
      guard++;
    end
    chk("reach_p40", 32'(posn[0]), 32'd40);
    rand_inputs(1);
    cycle(1'b1, 1'b1);
    repeat (250) begin
      rand_inputs(6);
      cycle(1'b0, ($urandom % 5) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
